// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the scanning N-channel multiplexer.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/rr_next_ch.sv
// Circular next-set-bit search: first set mask bit strictly after cur, modulo NCH.
// With cur = NCH-1 it returns the lowest set bit.
module rr_next_ch #(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [SELW-1:0] cur,
  input  logic [NCH-1:0]  mask,
  output logic [SELW-1:0] nxt,
  output logic            found,
  output logic            wrapped
);

  logic [SELW-1:0] idx;

  // Walk candidates from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = SELW'((int'(cur) + k) % NCH);
      if (mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    wrapped = found && (nxt <= cur);
  end

endmodule

// File: rtl/mux_scan_nch.sv
// Registered N-channel mux with manual select and round-robin scan over a
// channel mask, dwelling DWELL cycles per channel.
module mux_scan_nch
  import mux_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH),
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       ch_mask,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]     out,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_vld,
  output logic                 wrap
);

  localparam int              CW       = $clog2(DWELL + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
  localparam logic [SELW-1:0] LAST_CH  = SELW'(NCH - 1);

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            scan_act, scan_act_d;
  logic [WIDTH-1:0] out_d;
  logic [SELW-1:0] out_ch_d;
  logic            vld_d, wrap_d;

  logic [SELW-1:0] adv_ch, first_ch;
  logic            adv_found, adv_wrap, first_found, first_wrap;
  logic            sel_ok;
  logic            unused_flags;

  function automatic logic [WIDTH-1:0] pick(input logic [NCH*WIDTH-1:0] bus,
                                            input logic [SELW-1:0]      i_sel);
    pick = '0;
    for (int i = 0; i < NCH; i++)
      if (i_sel == SELW'(i)) pick = bus[i*WIDTH +: WIDTH];
  endfunction

  rr_next_ch #(.NCH(NCH), .SELW(SELW)) u_adv (
    .cur     (out_ch),
    .mask    (ch_mask),
    .nxt     (adv_ch),
    .found   (adv_found),
    .wrapped (adv_wrap)
  );

  rr_next_ch #(.NCH(NCH), .SELW(SELW)) u_first (
    .cur     (LAST_CH),
    .mask    (ch_mask),
    .nxt     (first_ch),
    .found   (first_found),
    .wrapped (first_wrap)
  );

  assign unused_flags = first_wrap ^ adv_found;
  assign sel_ok       = int'(sel) < NCH;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    scan_act_d = scan_act;
    out_d      = out;
    out_ch_d   = out_ch;
    vld_d      = 1'b0;
    wrap_d     = 1'b0;
    if (en) begin
      if (mode == MODE_MANUAL) begin
        state_d    = MANUAL;
        cnt_d      = '0;
        scan_act_d = 1'b0;
        out_ch_d   = sel;
        out_d      = sel_ok ? pick(in_data, sel) : '0;
        vld_d      = sel_ok;
      end else begin
        state_d = SCAN;
        if (!first_found) begin
          // Empty mask parks the scan; a later nonzero mask restarts it as an entry.
          cnt_d      = '0;
          scan_act_d = 1'b0;
        end else if (state != SCAN || !scan_act) begin
          out_ch_d   = first_ch;
          out_d      = pick(in_data, first_ch);
          cnt_d      = '0;
          scan_act_d = 1'b1;
          vld_d      = 1'b1;
        end else if (cnt == CNT_LAST) begin
          out_ch_d = adv_ch;
          out_d    = pick(in_data, adv_ch);
          cnt_d    = '0;
          wrap_d   = adv_wrap;
          vld_d    = 1'b1;
        end else begin
          out_d = pick(in_data, out_ch);
          cnt_d = cnt + CW'(1);
          vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      scan_act <= 1'b0;
      out      <= '0;
      out_ch   <= '0;
      out_vld  <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      scan_act <= scan_act_d;
      out      <= out_d;
      out_ch   <= out_ch_d;
      out_vld  <= vld_d;
      wrap     <= wrap_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_nch.sv
// Bench for mux_scan_nch: table of hand-computed vectors through an expected
// queue, random manual traffic, and a bounded wrap-period sequence.
module tb_mux_scan_nch;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;
  localparam int DWELL = 3;
  localparam int EW    = WIDTH + SELW + 2;
  localparam logic [NCH*WIDTH-1:0] D = 32'hDDCCBBAA;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH-1:0]       ch_mask;
  logic [NCH*WIDTH-1:0] in_data;
  logic [WIDTH-1:0]     out;
  logic [SELW-1:0]      out_ch;
  logic                 out_vld;
  logic                 wrap;

  typedef struct {
    logic                 rst_n;
    logic                 en;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [NCH-1:0]       mask;
    logic [NCH*WIDTH-1:0] data;
    logic [WIDTH-1:0]     e_out;
    logic [SELW-1:0]      e_ch;
    logic                 e_vld;
    logic                 e_wrap;
  } vec_t;

  vec_t           vecs[$];
  logic [EW-1:0]  exp_q[$];
  int             n_vec;
  int             n_err;

  mux_scan_nch #(.WIDTH(WIDTH), .NCH(NCH), .DWELL(DWELL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .sel     (sel),
    .ch_mask (ch_mask),
    .in_data (in_data),
    .out     (out),
    .out_ch  (out_ch),
    .out_vld (out_vld),
    .wrap    (wrap)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic void add(input logic r, input logic e, input logic m,
                              input logic [SELW-1:0] s, input logic [NCH-1:0] mk,
                              input logic [NCH*WIDTH-1:0] d, input logic [WIDTH-1:0] eo,
                              input logic [SELW-1:0] ec, input logic ev, input logic ew);
    vec_t v;
    v.rst_n = r;  v.en = e;  v.mode = m;  v.sel = s;  v.mask = mk;  v.data = d;
    v.e_out = eo; v.e_ch = ec; v.e_vld = ev; v.e_wrap = ew;
    vecs.push_back(v);
  endfunction

  // driver
  task automatic drive(input logic r, input logic e, input logic m, input logic [SELW-1:0] s,
                       input logic [NCH-1:0] mk, input logic [NCH*WIDTH-1:0] d);
    rst_n = r; en = e; mode = m; sel = s; ch_mask = mk; in_data = d;
  endtask

  // scoreboard
  task automatic check(input string name);
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got output with empty expected queue, want a queued expectation", name);
    end else begin
      e = exp_q.pop_front();
      if ({out, out_ch, out_vld, wrap} !== e) begin
        n_err++;
        $display("FAIL %s: got out=%h ch=%0d vld=%b wrap=%b, want out=%h ch=%0d vld=%b wrap=%b",
                 name, out, out_ch, out_vld, wrap,
                 e[EW-1 -: WIDTH], e[SELW+1:2], e[1], e[0]);
      end
    end
  endtask

  task automatic cmp_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic wait_wrap(input int budget, output int edges, output bit hit);
    edges = 0;
    hit   = 1'b0;
    while (!hit && edges < budget) begin
      @(posedge clk);
      #1;
      edges++;
      if (wrap) hit = 1'b1;
    end
  endtask

  initial begin
    logic [NCH*WIDTH-1:0] rd;
    logic [SELW-1:0]      rs;
    logic [WIDTH-1:0]     ro;
    int                   edges;
    bit                   hit;

    n_vec = 0;
    n_err = 0;
    drive(1'b0, 1'b1, 1'b1, 2'd0, 4'hF, D);

    // reset with scan requested, then release into scan entry
    add(0,1,1,0,4'hF,D,            8'h00,0,0,0);
    add(0,1,1,0,4'hF,D,            8'h00,0,0,0);
    add(1,1,1,0,4'hF,D,            8'hAA,0,1,0);
    // manual sweep
    add(1,1,0,0,4'hF,D,            8'hAA,0,1,0);
    add(1,1,0,1,4'hF,D,            8'hBB,1,1,0);
    add(1,1,0,2,4'hF,D,            8'hCC,2,1,0);
    add(1,1,0,3,4'hF,D,            8'hDD,3,1,0);
    // scan mask 1011, dwell 3, data change on channel 0 mid-dwell
    add(1,1,1,0,4'b1011,D,         8'hAA,0,1,0);
    add(1,1,1,0,4'b1011,D,         8'hAA,0,1,0);
    add(1,1,1,0,4'b1011,32'hDDCCBB11, 8'h11,0,1,0);
    add(1,1,1,0,4'b1011,D,         8'hBB,1,1,0);
    add(1,1,1,0,4'b1011,D,         8'hBB,1,1,0);
    add(1,1,1,0,4'b1011,D,         8'hBB,1,1,0);
    add(1,1,1,0,4'b1011,D,         8'hDD,3,1,0);
    add(1,1,1,0,4'b1011,D,         8'hDD,3,1,0);
    add(1,1,1,0,4'b1011,D,         8'hDD,3,1,0);
    add(1,1,1,0,4'b1011,D,         8'hAA,0,1,1);
    add(1,1,1,0,4'b1011,D,         8'hAA,0,1,0);
    // freeze for 5 cycles with counter at 1
    for (int i = 0; i < 5; i++)
      add(1,0,1,0,4'b1011,32'h12345678, 8'hAA,0,0,0);
    add(1,1,1,0,4'b1011,D,         8'hAA,0,1,0);
    add(1,1,1,0,4'b1011,D,         8'hBB,1,1,0);
    // empty mask, then single channel 2
    add(1,1,1,0,4'b0000,D,         8'hBB,1,0,0);
    add(1,1,1,0,4'b0000,32'h99999999, 8'hBB,1,0,0);
    add(1,1,1,0,4'b0100,D,         8'hCC,2,1,0);
    add(1,1,1,0,4'b0100,D,         8'hCC,2,1,0);
    add(1,1,1,0,4'b0100,D,         8'hCC,2,1,0);
    add(1,1,1,0,4'b0100,D,         8'hCC,2,1,1);
    add(1,1,1,0,4'b0100,D,         8'hCC,2,1,0);
    add(1,1,1,0,4'b0100,D,         8'hCC,2,1,0);
    add(1,1,1,0,4'b0100,D,         8'hCC,2,1,1);
    // current channel's mask bit dropped mid-dwell
    add(1,1,1,0,4'b0001,D,         8'hCC,2,1,0);
    add(1,1,1,0,4'b0001,D,         8'hCC,2,1,0);
    add(1,1,1,0,4'b0001,D,         8'hAA,0,1,1);
    // mode switches and reset mid-scan
    add(1,1,0,2,4'b0001,D,         8'hCC,2,1,0);
    add(1,1,1,0,4'hF,D,            8'hAA,0,1,0);
    add(1,1,1,0,4'hF,D,            8'hAA,0,1,0);
    add(0,1,1,0,4'hF,D,            8'h00,0,0,0);
    add(1,1,0,3,4'hF,D,            8'hDD,3,1,0);
    add(1,0,0,3,4'hF,D,            8'hDD,3,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].sel, vecs[i].mask, vecs[i].data);
      exp_q.push_back({vecs[i].e_out, vecs[i].e_ch, vecs[i].e_vld, vecs[i].e_wrap});
      check($sformatf("vec%0d", i));
    end

    // random manual traffic
    for (int i = 0; i < 10; i++) begin
      rd = $urandom();
      rs = SELW'($urandom_range(0, NCH - 1));
      ro = rd[rs*WIDTH +: WIDTH];
      drive(1'b1, 1'b1, 1'b0, rs, 4'hF, rd);
      exp_q.push_back({ro, rs, 1'b1, 1'b0});
      check($sformatf("rand%0d", i));
    end

    // wrap timing over mask 1011: entry edge plus 9 edges to first wrap, then every 9
    drive(1'b1, 1'b1, 1'b1, 2'd0, 4'b1011, D);
    wait_wrap(40, edges, hit);
    cmp_int("wrap_seen", int'(hit), 1);
    cmp_int("wrap_first", edges, 3 * DWELL + 1);
    cmp_int("wrap_ch", int'(out_ch), 0);
    wait_wrap(40, edges, hit);
    cmp_int("wrap_period", edges, 3 * DWELL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
